pc_update_sched: RTL and testbench
==================================

Name: pc_update_sched

Overview:
- Scheduler in front of the program-counter register.
- Arbitrates three PC-update sources (trap redirect, branch redirect, sequential increment) and issues one single-cycle write to the PC.
- The PC register ignores writes while a write is committing, so the scheduler holds off all further writes until the PC shows the new value.
- Sits between fetch/branch/trap logic and the PC register; pc_i is driven by the PC register's data output.

Parameters:
- XLEN, 32, PC and target width.
- PC_INC, 4, sequential increment added to pc_i.
- WAIT_CYCLES, 3, cycles the PC register needs after the write-enable cycle before pc_i shows the new value; must be at least 1.

Ports:
clk_i  in  1  clock, rising edge
i_rst  in  1  asynchronous active-low reset
hold_i  in  1  stall; blocks new grants only, in-flight writes still complete
trap_valid_i  in  1  trap redirect request
trap_target_i  in  XLEN  trap target
trap_ready_o  out  1  trap request accepted this cycle when high with valid
br_valid_i  in  1  branch redirect request
br_target_i  in  XLEN  branch target
br_ready_o  out  1  branch accept
seq_en_i  in  1  request sequential update PC+PC_INC; no ready, level-sampled
pc_i  in  XLEN  current PC from the PC register
pc_we_o  out  1  PC write enable, one-cycle pulse
pc_data_o  out  XLEN  value written to the PC
busy_o  out  1  write in flight (ISSUE or WAIT state)
commit_o  out  1  one-cycle pulse: pc_i now holds the last issued value
last_src_o  out  2  source of the last grant: 0 none, 1 trap, 2 branch, 3 seq
redirect_cnt_o  out  16  count of trap and branch grants; wraps at 2^16

Behaviour:
- Reset (asynchronous, i_rst low): state IDLE; pc_we_o=0, pc_data_o=0, busy_o=0, commit_o=0, last_src_o=0, redirect_cnt_o=0, wait counter=0.
- Reset mid-operation aborts the in-flight write with no commit_o. The PC register shares this reset, so both sides restart consistently.
- No acceptance occurs while i_rst is low.
- States:
  - IDLE: no write in flight.
  - ISSUE: pc_we_o=1 for exactly this one cycle.
  - WAIT: counter runs WAIT_CYCLES down to 1.
- Ready signals are combinational:
  - trap_ready_o = IDLE & !hold_i.
  - br_ready_o = IDLE & !hold_i & !trap_valid_i.
- Priority is trap > branch > seq. A seq grant occurs only in IDLE & !hold_i & !trap_valid_i & !br_valid_i & seq_en_i.
- Grant (at the rising edge ending the IDLE cycle):
  - pc_data_o is registered: trap_target_i, br_target_i, or pc_i+PC_INC (mod 2^XLEN, wraps silently).
  - last_src_o is updated.
  - redirect_cnt_o increments on trap or branch grants only.
  - Next state is ISSUE.
- ISSUE to WAIT: counter loads WAIT_CYCLES.
- WAIT: decrement each cycle. At counter==1 go to IDLE, with commit_o registered high for the first IDLE cycle.
- Timeline for WAIT_CYCLES=3:
  - Accept in cycle C0, pc_we_o in C1, WAIT in C2–C4, commit_o and new pc_i in C5.
  - Issue-to-visible latency 4 cycles; maximum throughput one update per 5 cycles.
- A new grant may occur in the commit_o cycle.
- pc_data_o holds its value until the next grant.
- Requesters must hold valid and target stable until ready. Target changes before acceptance are allowed; the value sampled at the accept edge is used.
- Simultaneous trap and branch: trap wins; the branch waits with ready low.
- hold_i asserted in ISSUE/WAIT has no effect on the in-flight write.
- Targets are passed unmodified (no alignment checks).

Decomposition:
- Package pc_sched_pkg holds:
  - state enum: ST_IDLE, ST_ISSUE, ST_WAIT.
  - source enum: SRC_NONE=0, SRC_TRAP=1, SRC_BR=2, SRC_SEQ=3.
  - default PC_INC and WAIT_CYCLES constants.
- One natural sub-module, pc_commit_timer: loadable down-counter with a done flag, instantiated for the WAIT phase.
- Arbitration and the FSM stay in the top level.

Test Plan:
- Reset, then seq_en_i=1 held with pc_i=0 and the PC model attached:
  - pc_we_o pulses with pc_data_o=0x4, then 0x8, then 0xC.
  - Pulses are 5 cycles apart; commit_o fires 4 cycles after each pc_we_o.
- Trap (0x100) and branch (0x200) valid in the same IDLE cycle:
  - Trap is accepted first (trap_ready_o=1, br_ready_o=0), pc_data_o=0x100, last_src_o=1.
  - The branch is accepted in the commit_o cycle and writes 0x200.
  - redirect_cnt_o=2.
- Branch valid while busy_o=1: br_ready_o stays 0 through ISSUE/WAIT, then the branch is accepted in the first IDLE cycle; exactly one pc_we_o per accept.
- hold_i=1 with all requests active: no grant and no pc_we_o. Release hold_i: grant next edge. hold_i asserted during WAIT: commit_o still occurs on schedule.
- pc_i=0xFFFFFFFC with seq_en_i=1: pc_data_o=0x00000000 (wrap); redirect_cnt_o unchanged.
- i_rst pulsed low during WAIT:
  - All outputs return to reset values immediately, with no commit_o.
  - After release, seq grant writes 0x4 from PC=0.

Source files
------------

// File: rtl/pc_update_sched_pkg.sv
// Shared types and defaults for the PC update scheduler.
// Holds the FSM state encoding, grant-source codes and parameter defaults.
package pc_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_TRAP = 2'd1,
        SRC_BR   = 2'd2,
        SRC_SEQ  = 2'd3
    } src_e;

    localparam int unsigned DEFAULT_PC_INC      = 4;
    localparam int unsigned DEFAULT_WAIT_CYCLES = 3;
    localparam int unsigned REDIRECT_CNT_W      = 16;

endpackage

// File: rtl/pc_update_sched_if.sv
// Request/response bundle between the PC update sources, the scheduler and the PC register.
// The scheduler takes the slave view; requesters and the PC register side take the master view.
interface pc_update_sched_if #(
    parameter int unsigned XLEN = 32
);

    logic            hold_i;
    logic            trap_valid_i;
    logic [XLEN-1:0] trap_target_i;
    logic            trap_ready_o;
    logic            br_valid_i;
    logic [XLEN-1:0] br_target_i;
    logic            br_ready_o;
    logic            seq_en_i;
    logic [XLEN-1:0] pc_i;
    logic            pc_we_o;
    logic [XLEN-1:0] pc_data_o;
    logic            busy_o;
    logic            commit_o;
    logic [1:0]      last_src_o;
    logic [15:0]     redirect_cnt_o;

    modport master (
        output hold_i, trap_valid_i, trap_target_i, br_valid_i, br_target_i, seq_en_i, pc_i,
        input  trap_ready_o, br_ready_o, pc_we_o, pc_data_o, busy_o, commit_o, last_src_o,
               redirect_cnt_o
    );

    modport slave (
        input  hold_i, trap_valid_i, trap_target_i, br_valid_i, br_target_i, seq_en_i, pc_i,
        output trap_ready_o, br_ready_o, pc_we_o, pc_data_o, busy_o, commit_o, last_src_o,
               redirect_cnt_o
    );

endinterface

// File: rtl/pc_commit_timer.sv
// Loadable down-counter timing how long the PC register needs to show a written value.
// done_o flags the last counted cycle (count == 1).
module pc_commit_timer #(
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             i_rst,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk_i or negedge i_rst) begin
        if (!i_rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = (count_q == Width'(1));

endmodule

// File: rtl/pc_update_sched.sv
// Arbitrates trap, branch and sequential PC updates and issues one PC write at a time,
// holding further writes off until the PC register shows the new value.
module pc_update_sched
    import pc_sched_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PC_INC      = DEFAULT_PC_INC,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input logic              clk_i,
    input logic              i_rst,
    pc_update_sched_if.slave bus
);

    localparam int unsigned CntW = $clog2(WAIT_CYCLES + 1);

    state_e                       state_q;
    logic                         pc_we_q;
    logic [XLEN-1:0]              pc_data_q;
    logic                         busy_q;
    logic                         commit_q;
    src_e                         last_src_q;
    logic [REDIRECT_CNT_W-1:0]    redirect_cnt_q;

    logic                         trap_ready;
    logic                         br_ready;
    src_e                         grant_src;
    logic [XLEN-1:0]              grant_data;
    logic                         timer_done;

    // Readies are gated by reset so nothing is ever accepted while i_rst is low.
    always_comb begin
        trap_ready = i_rst && (state_q == ST_IDLE) && !bus.hold_i;
        br_ready   = trap_ready && !bus.trap_valid_i;
        grant_src  = SRC_NONE;
        grant_data = '0;
        if (trap_ready && bus.trap_valid_i) begin
            grant_src  = SRC_TRAP;
            grant_data = bus.trap_target_i;
        end else if (br_ready && bus.br_valid_i) begin
            grant_src  = SRC_BR;
            grant_data = bus.br_target_i;
        end else if (br_ready && bus.seq_en_i) begin
            grant_src  = SRC_SEQ;
            grant_data = bus.pc_i + XLEN'(PC_INC);
        end
    end

    always_ff @(posedge clk_i or negedge i_rst) begin
        if (!i_rst) begin
            state_q        <= ST_IDLE;
            pc_we_q        <= 1'b0;
            pc_data_q      <= '0;
            busy_q         <= 1'b0;
            commit_q       <= 1'b0;
            last_src_q     <= SRC_NONE;
            redirect_cnt_q <= '0;
        end else begin
            pc_we_q  <= 1'b0;
            commit_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_src != SRC_NONE) begin
                        state_q    <= ST_ISSUE;
                        pc_we_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        pc_data_q  <= grant_data;
                        last_src_q <= grant_src;
                        if (grant_src inside {SRC_TRAP, SRC_BR}) begin
                            redirect_cnt_q <= redirect_cnt_q + 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (timer_done) begin
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                        commit_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    pc_commit_timer #(
        .Width (CntW)
    ) u_timer (
        .clk_i      (clk_i),
        .i_rst      (i_rst),
        .load_i     (state_q == ST_ISSUE),
        .load_val_i (CntW'(WAIT_CYCLES)),
        .dec_i      (state_q == ST_WAIT),
        .done_o     (timer_done)
    );

    assign bus.trap_ready_o   = trap_ready;
    assign bus.br_ready_o     = br_ready;
    assign bus.pc_we_o        = pc_we_q;
    assign bus.pc_data_o      = pc_data_q;
    assign bus.busy_o         = busy_q;
    assign bus.commit_o       = commit_q;
    assign bus.last_src_o     = last_src_q;
    assign bus.redirect_cnt_o = redirect_cnt_q;

endmodule

// File: tb/tb_pc_update_sched.sv
// Bench for pc_update_sched: directed scenarios plus random traffic, checked every cycle
// against a timeline model (cycles since last grant) and a delayed PC register model.
module tb_pc_update_sched;

    localparam int WAIT = 3;

    logic clk_i = 1'b0;
    logic i_rst = 1'b0;
    always #5 clk_i = ~clk_i;

    pc_update_sched_if #(.XLEN(32)) bus ();

    pc_update_sched #(
        .XLEN        (32),
        .PC_INC      (4),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk_i (clk_i),
        .i_rst (i_rst),
        .bus   (bus)
    );

    // PC register: a write becomes visible WAIT+1 cycles after the we cycle.
    logic [31:0] pc_reg;
    logic [WAIT-1:0] pv;
    logic [31:0] pd [WAIT];
    logic        pc_ovr_en = 1'b0;
    logic [31:0] pc_ovr_val = '0;

    always @(posedge clk_i or negedge i_rst) begin
        if (!i_rst) begin
            pc_reg <= '0;
            pv     <= '0;
            for (int k = 0; k < WAIT; k++) pd[k] <= '0;
        end else begin
            pv[0] <= bus.pc_we_o;
            pd[0] <= bus.pc_data_o;
            for (int k = 1; k < WAIT; k++) begin
                pv[k] <= pv[k-1];
                pd[k] <= pd[k-1];
            end
            if (pv[WAIT-1]) pc_reg <= pd[WAIT-1];
        end
    end

    assign bus.pc_i = pc_ovr_en ? pc_ovr_val : pc_reg;

    // Reference model: phase = cycles since the last grant edge (0 = nothing issued).
    int          phase;
    logic [31:0] m_data;
    logic [1:0]  m_src;
    logic [15:0] m_cnt;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] we_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        idle, tr, brr;
        int          g;
        logic [31:0] gd;
        #1;
        idle = (phase == 0) || (phase >= WAIT + 2);
        tr   = i_rst && idle && !bus.hold_i;
        brr  = tr && !bus.trap_valid_i;
        check("trap_ready", 32'(bus.trap_ready_o), 32'(tr));
        check("br_ready", 32'(bus.br_ready_o), 32'(brr));
        check("pc_we", 32'(bus.pc_we_o), 32'(phase == 1));
        check("busy", 32'(bus.busy_o), 32'(phase >= 1 && phase <= WAIT + 1));
        check("commit", 32'(bus.commit_o), 32'(phase == WAIT + 2));
        check("pc_data", bus.pc_data_o, m_data);
        check("last_src", 32'(bus.last_src_o), 32'(m_src));
        check("redirect_cnt", 32'(bus.redirect_cnt_o), 32'(m_cnt));
        if (bus.pc_we_o === 1'b1) we_log.push_back(bus.pc_data_o);
        g  = 0;
        gd = '0;
        if (tr && bus.trap_valid_i) begin
            g = 1; gd = bus.trap_target_i;
        end else if (brr && bus.br_valid_i) begin
            g = 2; gd = bus.br_target_i;
        end else if (brr && bus.seq_en_i) begin
            g = 3; gd = bus.pc_i + 32'd4;
        end
        @(posedge clk_i);
        if (g != 0) begin
            phase  = 1;
            m_data = gd;
            m_src  = 2'(g);
            if (g != 3) m_cnt = m_cnt + 16'd1;
        end else if (phase > 0 && phase < 100) begin
            phase++;
        end
        @(negedge clk_i);
        if (g == 1) bus.trap_valid_i = 1'b0;
        if (g == 2) bus.br_valid_i = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        i_rst  = 1'b0;
        phase  = 0;
        m_data = '0;
        m_src  = '0;
        m_cnt  = '0;
        repeat (cycles) step();
        i_rst = 1'b1;
    endtask

    initial begin
        logic [15:0] cnt_save;
        bus.hold_i        = 1'b0;
        bus.trap_valid_i  = 1'b0;
        bus.trap_target_i = '0;
        bus.br_valid_i    = 1'b0;
        bus.br_target_i   = '0;
        bus.seq_en_i      = 1'b0;
        apply_reset(2);

        // Sequential stream: 0x4, 0x8, 0xC, five cycles apart.
        bus.seq_en_i = 1'b1;
        repeat (16) step();
        bus.seq_en_i = 1'b0;
        while (we_log.size() < 3) we_log.push_back('x);
        check("seq_first", we_log[0], 32'h4);
        check("seq_second", we_log[1], 32'h8);
        check("seq_third", we_log[2], 32'hC);
        repeat (5) step();

        // Trap and branch together: trap first, branch in the commit cycle.
        bus.trap_target_i = 32'h100;
        bus.br_target_i   = 32'h200;
        bus.trap_valid_i  = 1'b1;
        bus.br_valid_i    = 1'b1;
        repeat (12) step();
        check("tb_redirect_cnt", 32'(bus.redirect_cnt_o), 32'd2);
        check("tb_last_src", 32'(bus.last_src_o), 32'd2);
        check("tb_last_data", bus.pc_data_o, 32'h200);

        // Branch arrives while busy.
        bus.seq_en_i = 1'b1;
        step();
        bus.seq_en_i    = 1'b0;
        bus.br_target_i = 32'h300;
        bus.br_valid_i  = 1'b1;
        repeat (12) step();

        // hold_i blocks grants; hold_i during WAIT does not delay the commit.
        bus.hold_i        = 1'b1;
        bus.trap_target_i = 32'h400;
        bus.br_target_i   = 32'h500;
        bus.trap_valid_i  = 1'b1;
        bus.br_valid_i    = 1'b1;
        bus.seq_en_i      = 1'b1;
        repeat (6) step();
        bus.hold_i = 1'b0;
        step();
        step();
        bus.hold_i = 1'b1;
        repeat (6) step();
        bus.hold_i   = 1'b0;
        bus.seq_en_i = 1'b0;
        repeat (12) step();

        // Sequential wrap at the top of the address space.
        cnt_save     = m_cnt;
        pc_ovr_val   = 32'hFFFF_FFFC;
        pc_ovr_en    = 1'b1;
        bus.seq_en_i = 1'b1;
        step();
        bus.seq_en_i = 1'b0;
        pc_ovr_en    = 1'b0;
        step();
        check("wrap_data", bus.pc_data_o, 32'h0);
        check("wrap_cnt", 32'(bus.redirect_cnt_o), 32'(cnt_save));
        repeat (5) step();

        // Reset in the middle of WAIT, then restart from PC=0.
        bus.seq_en_i = 1'b1;
        repeat (6) step();
        bus.seq_en_i = 1'b0;
        repeat (3) step();
        apply_reset(2);
        we_log.delete();
        bus.seq_en_i = 1'b1;
        repeat (3) step();
        bus.seq_en_i = 1'b0;
        if (we_log.size() == 0) we_log.push_back('x);
        check("post_reset_seq", we_log[0], 32'h4);
        repeat (5) step();

        // Random traffic; requesters hold valid until accepted, targets may move before that.
        for (int i = 0; i < 400; i++) begin
            if (!bus.trap_valid_i && ($urandom % 6 == 0)) bus.trap_valid_i = 1'b1;
            if (!bus.br_valid_i && ($urandom % 4 == 0)) bus.br_valid_i = 1'b1;
            if ($urandom % 3 == 0) bus.trap_target_i = $urandom;
            if ($urandom % 3 == 0) bus.br_target_i = $urandom;
            bus.hold_i   = ($urandom % 5 == 0);
            bus.seq_en_i = ($urandom % 2 == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
